// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device-generated clock falls, then checks
// the device acknowledge and waits for the bus to return to idle.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  localparam logic [19:0] INHIBIT_LAST  = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LIMIT = 20'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [9:0]  frame_q, frame_d;    // {stop, parity, data[7:0]}
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [19:0] timer_q, timer_d;    // inhibit timer, then frame timeout
  logic        dat_oe_q, dat_oe_d;
  logic [2:0]  clk_sync_q, clk_sync_d;  // [0]=sync1, [1]=sync2, [2]=sync3
  logic [2:0] dat_sync_q, dat_sync_d;
  logic        clk_fall;
  logic        timeout;

  // Shift the raw pins through the synchronizer chain.
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk_in};
    dat_sync_d = {dat_sync_q[1:0], ps2_dat_in};
  end

  assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign timeout  = (state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT_IDLE)
                    && (timer_q == TIMEOUT_LIMIT);

  // Next-state, datapath updates and one-cycle result pulses.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d  = state_q;
    frame_d  = frame_q;
    bitcnt_d = bitcnt_q;
    timer_d  = timer_q;
    dat_oe_d = dat_oe_q;
    tx_done  = 1'b0;
    tx_err   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          frame_d  = {1'b1, ~^tx_data, tx_data};
          bitcnt_d = 4'd0;
          timer_d  = 20'd0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == INHIBIT_LAST) begin
          dat_oe_d = 1'b1;  // start bit: data low while clock still held
          state_d  = S_REQ;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      S_REQ: begin
        timer_d = 20'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (timeout) begin
          dat_oe_d = 1'b0;
          tx_err   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 20'd1;
          if (clk_fall) begin
            dat_oe_d = ~frame_q[bitcnt_q];
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (timeout) begin
          dat_oe_d = 1'b0;
          tx_err   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 20'd1;
          if (clk_fall) begin
            if (dat_sync_q[1]) begin
              tx_err  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT_IDLE;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        if (timeout) begin
          dat_oe_d = 1'b0;
          tx_err   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 20'd1;
          if (clk_sync_q[1] && dat_sync_q[1]) begin
            tx_done = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      bitcnt_q   <= '0;
      timer_q    <= '0;
      dat_oe_q   <= 1'b0;
      // Idle bus level, so leaving reset never fabricates a clock fall.
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bitcnt_q   <= bitcnt_d;
      timer_q    <= timer_d;
      dat_oe_q   <= dat_oe_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
    end
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign ps2_clk_oe = (state_q == S_INHIBIT) || (state_q == S_REQ);
  assign ps2_dat_oe = dat_oe_q;

endmodule
